// File: rtl/cmuller_array.sv
// Clocked array of WIDTH multi-input C-Muller elements with asymmetric "plus-only" inputs,
// per-lane stuck-handshake detection and a global transition counter.
module cmuller_array #(
    parameter int              WIDTH   = 8,
    parameter int              NIN     = 2,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int              TMO_W   = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [WIDTH*NIN-1:0]   in,
    input  logic [WIDTH*NIN-1:0]   plus_mask,
    input  logic [TMO_W-1:0]       tmo_limit,
    input  logic                   clr,
    output logic [WIDTH-1:0]       c,
    output logic [WIDTH-1:0]       stall,
    output logic                   stall_any,
    output logic [15:0]            evt_cnt
);

    logic [WIDTH-1:0] c_r;
    logic [WIDTH-1:0] c_next_s;
    logic [WIDTH-1:0] pend_s;
    logic [WIDTH-1:0] stall_r;
    logic [WIDTH-1:0] stall_set_s;
    logic [TMO_W-1:0] cnt_r [WIDTH];
    logic [15:0]      evt_r;

    // A fully masked lane falls back to a plain symmetric join.
    function automatic logic [NIN-1:0] eff_mask(input logic [NIN-1:0] m);
        logic [NIN-1:0] r;
        if (&m) begin
            r = {NIN{1'b0}};
        end else begin
            r = m;
        end
        return r;
    endfunction

    function automatic logic lane_rise(input logic [NIN-1:0] v);
        return &v;
    endfunction

    function automatic logic lane_fall(input logic [NIN-1:0] v, input logic [NIN-1:0] m);
        return ~|(v & ~eff_mask(m));
    endfunction

    // Inputs disagreeing with the current output; plus inputs are ignored while c is high.
    function automatic logic lane_differs(input logic [NIN-1:0] v, input logic [NIN-1:0] m,
                                          input logic cur);
        logic d;
        if (cur) begin
            d = |(~v & ~eff_mask(m));
        end else begin
            d = |v;
        end
        return d;
    endfunction

    // Per-lane next output, pending detection and stall-set condition.
    always_comb begin
        c_next_s    = c_r;
        pend_s      = {WIDTH{1'b0}};
        stall_set_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (lane_rise(in[i*NIN +: NIN])) begin
                c_next_s[i] = 1'b1;
            end else if (lane_fall(in[i*NIN +: NIN], plus_mask[i*NIN +: NIN])) begin
                c_next_s[i] = 1'b0;
            end else begin
                c_next_s[i] = c_r[i];
                pend_s[i]   = lane_differs(in[i*NIN +: NIN], plus_mask[i*NIN +: NIN], c_r[i]);
            end
            if (pend_s[i] && (tmo_limit != {TMO_W{1'b0}}) &&
                (({1'b0, cnt_r[i]} + {{TMO_W{1'b0}}, 1'b1}) >= {1'b0, tmo_limit})) begin
                stall_set_s[i] = 1'b1;
            end else begin
                stall_set_s[i] = 1'b0;
            end
        end
    end

    // Lane outputs, saturating stall counters and sticky stall flags.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            c_r     <= RST_VAL;
            stall_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {TMO_W{1'b0}};
            end
        end else begin
            c_r <= c_next_s;
            for (int i = 0; i < WIDTH; i++) begin
                if (!pend_s[i]) begin
                    cnt_r[i] <= {TMO_W{1'b0}};
                end else if (cnt_r[i] != {TMO_W{1'b1}}) begin
                    cnt_r[i] <= cnt_r[i] + {{(TMO_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
            if (clr) begin
                stall_r <= {WIDTH{1'b0}};
            end else begin
                stall_r <= stall_r | stall_set_s;
            end
        end
    end

    // Activity counter: one tick per cycle with any output change, clr has priority.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            evt_r <= 16'd0;
        end else if (clr) begin
            evt_r <= 16'd0;
        end else if (c_next_s != c_r) begin
            evt_r <= evt_r + 16'd1;
        end else begin
            evt_r <= evt_r;
        end
    end

    assign c         = c_r;
    assign stall     = stall_r;
    assign stall_any = |stall_r;
    assign evt_cnt   = evt_r;

endmodule

// File: tb/tb_cmuller_array.sv
// Scoreboard bench for cmuller_array (WIDTH=4, NIN=3, RST_VAL=4'b1010): a behavioural
// model predicts each cycle's outputs when inputs are driven; results are checked after the edge.
module tb_cmuller_array;

    localparam int W  = 4;
    localparam int N  = 3;
    localparam int TW = 8;
    localparam logic [W-1:0] RV = 4'b1010;

    logic              clk = 1'b0;
    logic              rstn;
    logic [W*N-1:0]    din;
    logic [W*N-1:0]    dmask;
    logic [TW-1:0]     dtmo;
    logic              dclr;
    logic [W-1:0]      c;
    logic [W-1:0]      stall;
    logic              stall_any;
    logic [15:0]       evt_cnt;

    typedef struct packed {
        logic [W-1:0] c;
        logic [W-1:0] stall;
        logic [15:0]  evt;
    } exp_t;

    exp_t sbq[$];

    logic [W-1:0]  m_c;
    logic [W-1:0]  m_stall;
    logic [TW-1:0] m_cnt [W];
    logic [15:0]   m_evt;

    int vec_cnt = 0;
    int err_cnt = 0;

    cmuller_array #(.WIDTH(W), .NIN(N), .RST_VAL(RV), .TMO_W(TW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in        (din),
        .plus_mask (dmask),
        .tmo_limit (dtmo),
        .clr       (dclr),
        .c         (c),
        .stall     (stall),
        .stall_any (stall_any),
        .evt_cnt   (evt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [W*N-1:0] set_lane(input logic [W*N-1:0] v, input int l,
                                                input logic [N-1:0] b);
        logic [W*N-1:0] r;
        r = v;
        r[l*N +: N] = b;
        return r;
    endfunction

    task automatic model_reset();
        m_c     = RV;
        m_stall = '0;
        m_evt   = 16'd0;
        for (int l = 0; l < W; l++) m_cnt[l] = '0;
    endtask

    // Drive one cycle of inputs (caller sits at a falling edge), predict, then check.
    task automatic step(input logic [W*N-1:0] i_in, input logic [W*N-1:0] i_mask,
                        input logic [TW-1:0] i_tmo, input logic i_clr);
        logic [W-1:0] cn;
        logic [W-1:0] sn;
        logic         rise, fall, allm, differ, pend, b, m;
        exp_t         e;
        din = i_in; dmask = i_mask; dtmo = i_tmo; dclr = i_clr;
        sn = m_stall;
        for (int l = 0; l < W; l++) begin
            rise = 1'b1; fall = 1'b1; allm = 1'b1; differ = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (!i_mask[l*N+j]) allm = 1'b0;
                if (!i_in[l*N+j]) rise = 1'b0;
            end
            for (int j = 0; j < N; j++) begin
                b = i_in[l*N+j];
                m = i_mask[l*N+j] && !allm;
                if (b && !m) fall = 1'b0;
                if (b != m_c[l] && !(m_c[l] && m)) differ = 1'b1;
            end
            cn[l] = rise ? 1'b1 : (fall ? 1'b0 : m_c[l]);
            pend  = differ && !rise && !fall;
            if (pend && i_tmo != 0 && (int'(m_cnt[l]) + 1 >= int'(i_tmo))) sn[l] = 1'b1;
            if (!pend) m_cnt[l] = '0;
            else if (m_cnt[l] != 8'hFF) m_cnt[l] = m_cnt[l] + 8'd1;
        end
        if (i_clr) begin
            sn    = '0;
            m_evt = 16'd0;
        end else if (cn != m_c) begin
            m_evt = m_evt + 16'd1;
        end
        m_c = cn; m_stall = sn;
        sbq.push_back('{c: m_c, stall: m_stall, evt: m_evt});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("c", 32'(c), 32'(e.c));
        chk("stall", 32'(stall), 32'(e.stall));
        chk("stall_any", 32'(stall_any), 32'(|e.stall));
        chk("evt_cnt", 32'(evt_cnt), 32'(e.evt));
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_c"}, 32'(c), 32'(RV));
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_stall_any"}, 32'(stall_any), 32'd0);
        chk({tag, "_evt"}, 32'(evt_cnt), 32'd0);
    endtask

    logic [W*N-1:0] v;
    logic [W*N-1:0] mk;

    initial begin
        rstn = 1'b1; dclr = 1'b0; dtmo = 8'd0; dmask = '0;
        din  = 12'b111_000_111_000;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        step(din, '0, 8'd0, 1'b0);
        step(din, '0, 8'd0, 1'b0);
        chk("release_c", 32'(c), 32'(4'b1010));

        // symmetric 3-input join on lane 0
        v = din;
        v = set_lane(v, 0, 3'b000); step(v, '0, 8'd0, 1'b0);
        v = set_lane(v, 0, 3'b011); step(v, '0, 8'd0, 1'b0);
        v = set_lane(v, 0, 3'b111); step(v, '0, 8'd0, 1'b0);
        chk("join_rise_evt", 32'(evt_cnt), 32'd1);
        v = set_lane(v, 0, 3'b100); step(v, '0, 8'd0, 1'b0);
        v = set_lane(v, 0, 3'b000); step(v, '0, 8'd0, 1'b0);
        chk("join_fall_evt", 32'(evt_cnt), 32'd2);

        // asymmetric plus input on lane 0 bit 2
        mk = set_lane('0, 0, 3'b100);
        v = set_lane(v, 0, 3'b111); step(v, mk, 8'd0, 1'b0);
        v = set_lane(v, 0, 3'b100); step(v, mk, 8'd0, 1'b0);
        chk("plus_fall", 32'(c[0]), 32'd0);
        v = set_lane(v, 0, 3'b011); step(v, mk, 8'd1, 1'b0);
        chk("plus_pending", 32'(stall[0]), 32'd1);
        v = set_lane(v, 0, 3'b000); step(v, mk, 8'd0, 1'b1);

        // all inputs masked: symmetric behaviour
        mk = set_lane('0, 0, 3'b111);
        v = set_lane(v, 0, 3'b111); step(v, mk, 8'd0, 1'b0);
        v = set_lane(v, 0, 3'b100); step(v, mk, 8'd0, 1'b0);
        v = set_lane(v, 0, 3'b000); step(v, mk, 8'd0, 1'b0);

        // timeout on lane 2
        for (int k = 0; k < 10; k++) begin
            v = set_lane(v, 2, 3'b001); step(v, '0, 8'd5, 1'b0);
        end
        v = set_lane(v, 2, 3'b111); step(v, '0, 8'd5, 1'b0);
        chk("tmo_held", 32'(stall[2]), 32'd1);
        step(v, '0, 8'd5, 1'b1);

        // clr collision: lane 2 pending high with tmo=1
        v = set_lane(v, 2, 3'b011); step(v, '0, 8'd1, 1'b1);
        step(v, '0, 8'd1, 1'b0);
        v = set_lane(v, 2, 3'b111);
        v = set_lane(v, 0, 3'b111); step(v, '0, 8'd0, 1'b1);
        chk("clr_vs_evt", 32'(evt_cnt), 32'd0);

        // build evt_cnt=0xFF, stall[1]=1, cnt[0]=3 then pulse reset between edges
        for (int k = 0; k < 255; k++) begin
            v = set_lane(v, 3, m_c[3] ? 3'b000 : 3'b111); step(v, '0, 8'd0, 1'b0);
        end
        v = set_lane(v, 1, m_c[1] ? 3'b011 : 3'b001); step(v, '0, 8'd1, 1'b0);
        v = set_lane(v, 1, m_c[1] ? 3'b111 : 3'b000);
        for (int k = 0; k < 3; k++) begin
            v = set_lane(v, 0, m_c[0] ? 3'b110 : 3'b001); step(v, '0, 8'd0, 1'b0);
        end
        chk("pre_reset_evt", 32'(evt_cnt), 32'h00FF);
        #2 rstn = 1'b1;
        #1 check_reset_outputs("async_reset");
        #1 rstn = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            v = set_lane(v, 0, m_c[0] ? 3'b110 : 3'b001); step(v, '0, 8'd3, 1'b0);
        end

        // evt_cnt wraps after 65536 changing cycles
        step('0, '0, 8'd0, 1'b0);
        step('0, '0, 8'd0, 1'b1);
        v = '0;
        for (int k = 0; k < 65536; k++) begin
            v = set_lane(v, 3, m_c[3] ? 3'b000 : 3'b111); step(v, '0, 8'd0, 1'b0);
        end
        chk("evt_wrap", 32'(evt_cnt), 32'd0);
        chk("sbq_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
